// File: rtl/div8_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
package div8_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div8_seq_ripple_sub.sv
// Ripple-borrow subtractor: diff = a - b, borrow_out set when a < b.
module ripple_sub #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  logic [W:0] w_borrow;

  assign w_borrow[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_fs
    assign diff[i]       = a[i] ^ b[i] ^ w_borrow[i];
    assign w_borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
  end

  assign borrow_out = w_borrow[W];

endmodule

// File: rtl/div8_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
module div8_seq
  import div8_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_divisor;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH:0]   w_t;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH:0]   w_rem_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_unused;

  // Partial remainder is always below the divisor, so its top bit never feeds the shift.
  assign w_t      = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_unused = r_rem[WIDTH];

  ripple_sub #(.W(WIDTH + 1)) u_sub (
    .a          (w_t),
    .b          ({1'b0, r_divisor}),
    .diff       (w_diff),
    .borrow_out (w_borrow)
  );

  assign w_rem_next = w_borrow ? w_t : w_diff;
  assign w_q_next   = {r_q[WIDTH-2:0], ~w_borrow};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_divisor   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
          if (start) begin
            if (divisor != '0) begin
              r_rem     <= '0;
              r_q       <= dividend;
              r_divisor <= divisor;
              r_cnt     <= CW'(WIDTH - 1);
              r_busy    <= 1'b1;
              r_state   <= RUN;
            end else begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        RUN: begin
          r_q   <= w_q_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_rem_next[WIDTH-1:0];
            r_dbz       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
